// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: arm / trigger / post-trigger delay / burst-write sequencer
// for the ADC capture BRAM. It drives word-aligned byte addresses and all-or-
// nothing byte write enables, and reports busy, done and a completed-capture
// count back to the register interface.
//
// The debug output state_dbg carries the current FSM state
// (0 IDLE, 1 ARMED, 2 DELAY, 3 CAPTURE, 4 DONE).
//
// Control handshake: arm and abort are single-cycle requests and are sampled
// on every rising edge of clk, with no ready/ack signal. abort wins over
// everything else. arm is accepted only in IDLE or DONE. clken qualifies
// samples, so DELAY and CAPTURE advance only on cycles where clken is high.
module bram_capture_ctrl #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clken,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig_sel,
  input  logic                   trig_sw,
  input  logic                   trig_ext,
  input  logic [ADDR_WIDTH-1:0]  length,
  input  logic [DELAY_WIDTH-1:0] delay,
  output logic [31:0]            address,
  output logic [3:0]             wen,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            capture_count,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_n;

  // The word index is one bit wider than the address so that a full-depth
  // burst length (2^ADDR_WIDTH) is representable. The last index, N-1, always
  // fits in ADDR_WIDTH bits: length-1 wraps to all ones when length is 0.
  logic [ADDR_WIDTH:0]    idx;
  logic [ADDR_WIDTH-1:0]  last_idx;
  logic [DELAY_WIDTH-1:0] dly_l;
  logic [DELAY_WIDTH-1:0] dcnt;
  logic                   trig_ext_d;

  logic trig_evt;
  logic load;
  logic do_write;
  logic last_write;
  logic dcnt_inc;

  // The external trigger is a rising edge. The software trigger is a level.
  assign trig_evt  = trig_sel ? (trig_ext & ~trig_ext_d) : trig_sw;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state logic and datapath strobes; abort overrides every other request.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    do_write   = 1'b0;
    last_write = 1'b0;
    dcnt_inc   = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            load    = 1'b1;
            state_n = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_evt) state_n = (dly_l != '0) ? S_DELAY : S_CAPTURE;
        end
        S_DELAY: begin
          if (clken) begin
            dcnt_inc = 1'b1;
            if (dcnt == dly_l - DELAY_WIDTH'(1)) state_n = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (clken) begin
            do_write = 1'b1;
            if (idx == {1'b0, last_idx}) begin
              last_write = 1'b1;
              state_n    = S_DONE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath: latched parameters, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx           <= '0;
      last_idx      <= '0;
      dly_l         <= '0;
      dcnt          <= '0;
      trig_ext_d    <= 1'b1;
      address       <= '0;
      wen           <= 4'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      capture_count <= '0;
    end else begin
      trig_ext_d <= trig_ext;
      wen        <= do_write ? 4'hF : 4'h0;
      busy       <= (state_n == S_ARMED) || (state_n == S_DELAY) ||
                    (state_n == S_CAPTURE);
      done       <= (state_n == S_DONE);
      if (load) begin
        idx      <= '0;
        dcnt     <= '0;
        last_idx <= length - ADDR_WIDTH'(1);
        dly_l    <= delay;
      end
      if (dcnt_inc) dcnt <= dcnt + DELAY_WIDTH'(1);
      if (do_write) begin
        address <= 32'(idx[ADDR_WIDTH-1:0]) << 2;
        idx     <= idx + (ADDR_WIDTH+1)'(1);
      end
      if (last_write) capture_count <= capture_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl. A table of per-cycle vectors covers the basic
// software-triggered burst. Hand-written sequences cover the edge trigger,
// gated delay, abort, full depth and re-arm.
module tb_bram_capture_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          clken    = 1'b0;
  logic          arm      = 1'b0;
  logic          abort    = 1'b0;
  logic          trig_sel = 1'b0;
  logic          trig_sw  = 1'b0;
  logic          trig_ext = 1'b0;
  logic [AW-1:0] length   = '0;
  logic [DW-1:0] delay    = '0;
  logic [31:0]   address;
  logic [3:0]    wen;
  logic          busy;
  logic          done;
  logic [31:0]   capture_count;
  logic [2:0]    state_dbg;

  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        arm;
    logic        trig_sw;
    logic        clken;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  bram_capture_ctrl #(.ADDR_WIDTH(AW), .DELAY_WIDTH(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .clken         (clken),
    .arm           (arm),
    .abort         (abort),
    .trig_sel      (trig_sel),
    .trig_sw       (trig_sw),
    .trig_ext      (trig_ext),
    .length        (length),
    .delay         (delay),
    .address       (address),
    .wen           (wen),
    .busy          (busy),
    .done          (done),
    .capture_count (capture_count),
    .state_dbg     (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ew, input logic [31:0] ea,
                         input logic eb, input logic ed, input logic [31:0] ec);
    chk({tag, " wen"}, {28'd0, wen}, {28'd0, ew});
    chk({tag, " address"}, address, ea);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, " done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, " count"}, capture_count, ec);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] es);
    chk({tag, " state"}, {29'd0, state_dbg}, {29'd0, es});
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect n consecutive writes from the scoreboard queue. arm is pulsed at
  // write arm_at to confirm it is ignored during CAPTURE.
  task automatic burst_check(input string tag, input int n, input int arm_at);
    for (int i = 0; i < n; i++) exp_q.push_back(32'(i) * 32'd4);
    for (int c = 0; c < n; c++) begin
      arm = (c == arm_at);
      tick();
      chk($sformatf("%s wen%0d", tag, c), {28'd0, wen}, 32'hF);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s queue: got write with empty expected queue", tag);
      end else begin
        chk($sformatf("%s addr%0d", tag, c), address, exp_q.pop_front());
      end
      if (c == n - 1) begin
        chk({tag, " last done"}, {31'd0, done}, 32'd1);
        chk({tag, " last busy"}, {31'd0, busy}, 32'd0);
      end
    end
    arm = 1'b0;
  endtask

  initial begin
    // Reset.
    repeat (2) tick();
    chk_out("reset", 4'h0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk_state("reset", ST_IDLE);
    resetn = 1'b1;

    // Basic software trigger, table driven.
    length   = 5'd8;
    delay    = '0;
    trig_sel = 1'b0;
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0, 32'd0, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h0, 32'd0, 1'b1, 1'b0, 32'd0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 32'(i) * 32'd4, (i != 7), (i == 7),
                       (i == 7) ? 32'd1 : 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'h0, 32'd28, 1'b0, 1'b1, 32'd1});
    for (int k = 0; k < vecs.size(); k++) begin
      arm     = vecs[k].arm;
      trig_sw = vecs[k].trig_sw;
      clken   = vecs[k].clken;
      tick();
      chk_out($sformatf("vec%0d", k), vecs[k].wen, vecs[k].addr, vecs[k].busy,
              vecs[k].done, vecs[k].cnt);
    end
    exp_cnt = 32'd1;

    // External edge trigger held high through reset and arm.
    trig_sel = 1'b1;
    trig_ext = 1'b1;
    resetn   = 1'b0;
    repeat (2) tick();
    chk_out("ext reset", 4'h0, 32'd0, 1'b0, 1'b0, 32'd0);
    exp_cnt = 32'd0;
    resetn  = 1'b1;
    length  = 5'd2;
    arm     = 1'b1;
    tick();
    arm = 1'b0;
    chk("ext armed busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("ext hold%0d", i), ST_ARMED);
      chk($sformatf("ext hold%0d wen", i), {28'd0, wen}, 32'd0);
    end
    trig_ext = 1'b0;
    tick();
    chk_state("ext low", ST_ARMED);
    trig_ext = 1'b1;
    tick();
    chk_state("ext rise", ST_CAPTURE);
    chk("ext rise wen", {28'd0, wen}, 32'd0);
    tick();
    chk_out("ext w0", 4'hF, 32'd0, 1'b1, 1'b0, 32'd0);
    tick();
    chk_out("ext w1", 4'hF, 32'd4, 1'b0, 1'b1, 32'd1);
    tick();
    chk_out("ext after", 4'h0, 32'd4, 1'b0, 1'b1, 32'd1);
    exp_cnt  = 32'd1;
    trig_ext = 1'b0;

    // Delay 3 with clken alternating 1/0 after the trigger.
    trig_sel = 1'b0;
    length   = 5'd4;
    delay    = 16'd3;
    clken    = 1'b1;
    arm      = 1'b1;
    tick();
    arm     = 1'b0;
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    chk_state("dly trig", ST_DELAY);
    for (int k = 1; k <= 14; k++) begin
      clken = (k % 2 == 1);
      tick();
      chk($sformatf("dly k%0d wen", k), {28'd0, wen},
          (k >= 7 && k % 2 == 1) ? 32'hF : 32'h0);
      if (k >= 7 && k % 2 == 1)
        chk($sformatf("dly k%0d addr", k), address, 32'((k - 7) / 2) * 32'd4);
      chk($sformatf("dly k%0d busy", k), {31'd0, busy}, (k < 13) ? 32'd1 : 32'd0);
      chk($sformatf("dly k%0d done", k), {31'd0, done}, (k >= 13) ? 32'd1 : 32'd0);
      if (k == 4) chk_state("dly k4", ST_DELAY);
      if (k == 5) chk_state("dly k5", ST_CAPTURE);
    end
    exp_cnt = 32'd2;
    chk("dly count", capture_count, exp_cnt);

    // Abort after five writes of a 16-word burst.
    clken  = 1'b1;
    delay  = '0;
    length = 5'd16;
    arm    = 1'b1;
    tick();
    arm     = 1'b0;
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("abort w%0d wen", i), {28'd0, wen}, 32'hF);
      chk($sformatf("abort w%0d addr", i), address, 32'(i) * 32'd4);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("abort", 4'h0, 32'd16, 1'b0, 1'b0, exp_cnt);
    chk_state("abort", ST_IDLE);
    tick();
    chk_state("abort hold", ST_IDLE);
    chk("abort hold wen", {28'd0, wen}, 32'd0);
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    chk_state("arm+abort", ST_IDLE);
    chk("arm+abort busy", {31'd0, busy}, 32'd0);
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    chk_state("idle trig", ST_IDLE);
    chk("idle trig wen", {28'd0, wen}, 32'd0);

    // Full depth (length 0 means 32 words), with arm ignored mid-burst.
    length = '0;
    arm    = 1'b1;
    tick();
    arm     = 1'b0;
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    burst_check("full", 32, 10);
    exp_cnt = 32'd3;
    chk("full count", capture_count, exp_cnt);
    chk("full last addr", address, 32'd124);
    tick();
    chk_out("full after", 4'h0, 32'd124, 1'b0, 1'b1, exp_cnt);

    // Trigger in DONE is ignored, then re-arm restarts at address 0.
    trig_sw = 1'b1;
    tick();
    chk_state("done trig", ST_DONE);
    chk("done trig wen", {28'd0, wen}, 32'd0);
    trig_sw = 1'b0;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    burst_check("rearm", 32, -1);
    exp_cnt = 32'd4;
    chk("rearm count", capture_count, exp_cnt);
    tick();
    chk("rearm after wen", {28'd0, wen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_capture_ctrl.md
# bram_capture_ctrl

Sequencer for the ADC-to-BRAM capture path. Software arms it with a length and a post-trigger delay. It waits for a software or external trigger, counts out the delay, then writes a burst of 32-bit words into the capture BRAM by driving the byte address and byte write enables. It sits between the register interface and the capture BRAM port, and reports `busy`, `done` and a running capture count back to software.

## Interface
- `ADDR_WIDTH`, 13, log2 of BRAM depth in 32-bit words.
- `DELAY_WIDTH`, 16, width of the post-trigger delay counter.

- `clk`  in  1  capture clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `clken`  in  1  sample-valid qualifier; delay and capture advance only when high.
- `arm`  in  1  single-cycle arm request.
- `abort`  in  1  single-cycle abort request.
- `trig_sel`  in  1  trigger source: 0 selects `trig_sw` (level), 1 selects `trig_ext` (rising edge).
- `trig_sw`  in  1  software trigger, level-sensitive.
- `trig_ext`  in  1  external trigger, already synchronous to `clk`.
- `length`  in  ADDR_WIDTH  words to capture; 0 means 2^ADDR_WIDTH.
- `delay`  in  DELAY_WIDTH  qualified samples skipped between trigger and first write.
- `address`  out  32  BRAM byte address = word index << 2, zero-extended.
- `wen`  out  4  BRAM byte write enables; 4'hF or 4'h0 only.
- `busy`  out  1  high in ARMED, DELAY and CAPTURE.
- `done`  out  1  high in DONE.
- `capture_count`  out  32  number of completed captures; wraps modulo 2^32.

## Operation
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- Reset: state IDLE; `address` = 0, `wen` = 0, `busy` = 0, `done` = 0, `capture_count` = 0; edge register `trig_ext_d` = 1, so a trigger held high through reset does not fire.
- IDLE or DONE, `arm` = 1: latch `length` and `delay`, clear word index and delay counter, go to ARMED.
- `arm` in ARMED, DELAY or CAPTURE is ignored. Triggers outside ARMED are ignored.
- Trigger event is `trig_sel ? (trig_ext & ~trig_ext_d) : trig_sw`. It is evaluated in ARMED only and is not qualified by `clken`.
- ARMED, trigger event: go to DELAY if latched delay ≠ 0, otherwise go to CAPTURE.
- DELAY: increment the counter on each `clken` cycle. When the counter reaches delay − 1 with `clken` high, go to CAPTURE.
- CAPTURE, `clken` = 1: register `wen` = 4'hF and `address` = index << 2, then increment the index.
  - When index = N − 1 (N = latched length, or 2^ADDR_WIDTH if 0), also go to DONE and increment `capture_count` on the same edge.
- CAPTURE, `clken` = 0: `wen` registers 0; index holds.
- `wen` registers 0 in every state except CAPTURE with `clken` = 1. `address` holds its last value otherwise.
- Word index is ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH is representable. `address` never exceeds (2^ADDR_WIDTH − 1) << 2.
- `abort` = 1 in any state: go to IDLE next edge with `wen` = 0 and `done` = 0. `capture_count` is unchanged. `abort` takes priority over `arm`, a trigger event and last-word completion in the same cycle.
- `resetn` low mid-capture: reset values on the next edge; no further writes.

## Timing
- `arm` sampled at edge A: `busy` = 1 after A.
- Trigger sampled at edge T with delay 0 and `clken` held high:
  - state CAPTURE after T;
  - first `wen` = 4'hF, `address` = 0 after T+1;
  - the BRAM write occurs at T+2.
- With delay D and `clken` held high, the first `wen` appears after edge T+D+1.
- Last word registered at edge L: `wen` = 4'hF and `done` = 1 after L; `busy` = 0 after L; `wen` = 0 after L+1.
- All outputs are registered; there is no combinational path from any input to any output.
- Burst throughput is one word per `clken` cycle.

## Test plan
- **Basic software trigger:** `length` = 8, `delay` = 0, `trig_sel` = 0, `clken` = 1; arm, then pulse `trig_sw`. Required: exactly 8 `wen` = 4'hF cycles with `address` 0, 4, …, 28, starting two edges after the trigger; then `done` = 1, `busy` = 0, `capture_count` = 1.
- **External edge trigger:** `trig_ext` held high through reset and arm. Required: no capture. Then drop and raise `trig_ext`: capture starts 2 edges after the rise.
- **Delay with gated `clken`:** `delay` = 3, `length` = 4, `clken` alternating 1/0. Required: writes begin only after 3 qualified samples; `wen` is high only on `clken` cycles; addresses are 0, 4, 8, 12 with no gaps or repeats.
- **Abort and arm priority:** assert `abort` after 5 writes of `length` = 16. Required: `wen` = 0 next cycle, state IDLE, `done` = 0, `capture_count` unchanged. `arm` and `abort` in the same cycle leaves the block in IDLE.
- **Full depth and re-arm:** `ADDR_WIDTH` = 5, `length` = 0. Required: 32 writes, last `address` = 124, `done` = 1. Re-arm from DONE and capture again: `capture_count` = 2, addresses restart at 0.
- **Ignored requests:** `arm` during CAPTURE and triggers in IDLE or DONE. Required: no effect on state, `address` or `wen`.
